alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with single-cycle arithmetic/logic, iterative shifts and shift-add multiply
module alu_seq #(
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry,
  output logic       overflow,
  output logic       flag_we,
  output logic       wb
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op_r, cnt;
  logic [7:0] a_r, r1, sh;
  logic [15:0] prod, prod_nx;
  logic [8:0] sum9, dif9, ms;
  logic c1, v1, sc, rsv, multi, accept, mul_op;
  assign mul_op = op_r == 4'd11;
  assign rsv = (op >= 4'd13) || (op == 4'd11 && !MUL_ENABLE);
  assign multi = !rsv && (op == 4'd11 || ((op == 4'd8 || op == 4'd9 || op == 4'd10) && b[2:0] != 3'd0));
  assign accept = start && state == IDLE;
  // single-cycle results computed straight from the operands being accepted
  always_comb begin
    sum9 = {1'b0, a} + {1'b0, b} + {8'd0, op == 4'd1 && cin};
    dif9 = {1'b0, a} - {1'b0, b} - {8'd0, op == 4'd3 && cin};
    r1 = 8'd0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        r1 = sum9[7:0];
        c1 = sum9[8];
        v1 = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      4'd2, 4'd3, 4'd12: begin
        r1 = dif9[7:0];
        c1 = dif9[8];
        v1 = (a[7] != b[7]) && (dif9[7] != a[7]);
      end
      4'd4: r1 = a & b;
      4'd5: r1 = a | b;
      4'd6: r1 = a ^ b;
      4'd7: r1 = ~a;
      4'd8, 4'd9, 4'd10: r1 = a;
      default: ;
    endcase
  end
  // one shift step and one shift-add multiply step on the latched working registers
  always_comb begin
    sh = op_r == 4'd8 ? {a_r[6:0], 1'b0} : {op_r == 4'd10 && a_r[7], a_r[7:1]};
    sc = op_r == 4'd8 ? a_r[7] : a_r[0];
    ms = {1'b0, prod[15:8]} + (prod[0] ? {1'b0, a_r} : 9'd0);
    prod_nx = {ms, prod[7:1]};
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and status outputs
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = multi ? EXEC : DONE;
      EXEC: if (cnt == 4'd1) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy = state != IDLE;
    done = state == DONE;
    flag_we = done && op_r <= 4'd12 && !(mul_op && !MUL_ENABLE);
    wb = done && op_r <= 4'd11 && !(mul_op && !MUL_ENABLE);
  end
  // operand latching, iteration, and result registers loaded only on entry to DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= 4'd0;
      a_r <= 8'd0;
      prod <= 16'd0;
      cnt <= 4'd0;
      result <= 8'd0;
      carry <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_r <= op;
      a_r <= a;
      prod <= {8'd0, b};
      cnt <= op == 4'd11 ? 4'd8 : {1'b0, b[2:0]};
      if (!multi) begin
        result <= r1;
        carry <= c1;
        overflow <= v1;
      end
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      a_r <= mul_op ? a_r : sh;
      prod <= prod_nx;
      if (cnt == 4'd1) begin
        result <= mul_op ? prod_nx[7:0] : sh;
        carry <= mul_op ? |prod_nx[15:8] : sc;
        overflow <= 1'b0;
      end
    end
endmodule
